// File: rtl/psd_multi.sv
// psd_multi: multi-pattern serial sequence detector.
// Ports: clk/resetn (sync, active-low); cfg_* write a pattern slot and
//   cfg_err flags a rejected write; din_valid/din carry the bit stream;
//   overlap selects match mode; cnt_clr clears hit_cnt; hit/hit_any/
//   hit_idx/hit_cnt report matches one cycle after the final bit.
module psd_multi #(
   parameter int MAX_LEN = 8,
   parameter int NUM_PAT = 4,
   parameter int CNT_W   = 8,
   localparam int LW = $clog2(MAX_LEN + 1),
   localparam int IW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               cfg_we,
   input  logic [IW-1:0]      cfg_idx,
   input  logic [LW-1:0]      cfg_len,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic               cfg_en,
   output logic               cfg_err,
   input  logic               din_valid,
   input  logic               din,
   input  logic               overlap,
   input  logic               cnt_clr,
   output logic [NUM_PAT-1:0] hit,
   output logic               hit_any,
   output logic [IW-1:0]      hit_idx,
   output logic [CNT_W-1:0]   hit_cnt
);

   localparam logic [LW-1:0]    LEN_MAX = LW'(MAX_LEN);
   localparam logic [IW:0]      PAT_NUM = (IW+1)'(NUM_PAT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic               en_q   [NUM_PAT];
   logic               en_d   [NUM_PAT];
   logic [LW-1:0]      len_q  [NUM_PAT];
   logic [LW-1:0]      len_d  [NUM_PAT];
   logic [MAX_LEN-1:0] pat_q  [NUM_PAT];
   logic [MAX_LEN-1:0] pat_d  [NUM_PAT];
   logic [LW-1:0]      fill_q [NUM_PAT];
   logic [LW-1:0]      fill_d [NUM_PAT];

   logic [MAX_LEN-1:0] hist_q, hist_d, hist_new;
   logic [NUM_PAT-1:0] hit_q, hit_d;
   logic               any_q, any_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               cfg_ok;

   // Fill counts beats since the slot was (re)armed; a match needs at
   // least len beats in that window, compared one bit wider so that
   // fill+1 cannot wrap.
   function automatic logic slot_match(
      input logic               en,
      input logic [LW-1:0]      fill,
      input logic [LW-1:0]      len,
      input logic [MAX_LEN-1:0] pat,
      input logic [MAX_LEN-1:0] hist
   );
      logic [LW:0]        fill_p1;
      logic [MAX_LEN-1:0] mask;
      fill_p1 = {1'b0, fill} + (LW+1)'(1);
      mask    = ~({MAX_LEN{1'b1}} << len);
      return en && (fill_p1 >= {1'b0, len}) &&
             (((hist ^ pat) & mask) == '0);
   endfunction

   function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] f);
      return (f == LEN_MAX) ? f : f + LW'(1);
   endfunction

   assign cfg_ok = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_MAX) &&
                   ({1'b0, cfg_idx} < PAT_NUM);

   assign hist_new = {hist_q[MAX_LEN-2:0], din};

   always_comb begin
      hist_d = din_valid ? hist_new : hist_q;
      err_d  = cfg_we && !cfg_ok;
      hit_d  = '0;
      for (int i = 0; i < NUM_PAT; i++) begin
         en_d[i]   = en_q[i];
         len_d[i]  = len_q[i];
         pat_d[i]  = pat_q[i];
         fill_d[i] = fill_q[i];
         // A write takes the slot out of this cycle's beat entirely.
         if (cfg_ok && (cfg_idx == IW'(i))) begin
            en_d[i]   = cfg_en;
            len_d[i]  = cfg_len;
            pat_d[i]  = cfg_pattern;
            fill_d[i] = '0;
         end else if (din_valid) begin
            fill_d[i] = sat_inc(fill_q[i]);
            if (slot_match(en_q[i], fill_q[i], len_q[i],
                           pat_q[i], hist_new)) begin
               hit_d[i] = 1'b1;
               if (!overlap)
                  fill_d[i] = '0;
            end
         end
      end
   end

   always_comb begin
      any_d = |hit_d;
      idx_d = '0;
      for (int i = NUM_PAT - 1; i >= 0; i--)
         if (hit_d[i])
            idx_d = IW'(i);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (any_d && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_PAT; i++) begin
            en_q[i]   <= 1'b0;
            len_q[i]  <= '0;
            pat_q[i]  <= '0;
            fill_q[i] <= '0;
         end
         hist_q <= '0;
         hit_q  <= '0;
         any_q  <= 1'b0;
         idx_q  <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PAT; i++) begin
            en_q[i]   <= en_d[i];
            len_q[i]  <= len_d[i];
            pat_q[i]  <= pat_d[i];
            fill_q[i] <= fill_d[i];
         end
         hist_q <= hist_d;
         hit_q  <= hit_d;
         any_q  <= any_d;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign hit     = hit_q;
   assign hit_any = any_q;
   assign hit_idx = idx_q;
   assign hit_cnt = cnt_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_psd_multi.sv
// tb_psd_multi: directed and random bench for psd_multi.
// Reference model tracks the received bit stream and per-slot arm points.
module tb_psd_multi;

   localparam int ML = 8;
   localparam int NP = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_idx = '0;
   logic [3:0]    cfg_len = '0;
   logic [ML-1:0] cfg_pattern = '0;
   logic          cfg_en = 1'b0;
   logic          cfg_err;
   logic          din_valid = 1'b0;
   logic          din = 1'b0;
   logic          overlap = 1'b1;
   logic          cnt_clr = 1'b0;
   logic [NP-1:0] hit;
   logic          hit_any;
   logic [1:0]    hit_idx;
   logic [CW-1:0] hit_cnt;

   int n_assert = 0;
   int n_fail = 0;

   // reference model state
   bit          m_en [NP];
   int          m_len [NP];
   logic [7:0]  m_pat [NP];
   int          m_start [NP];
   int          nb;
   bit          strm [$];
   logic [3:0]  e_hit;
   int          e_cnt;
   logic        e_err;

   psd_multi #(.MAX_LEN(ML), .NUM_PAT(NP), .CNT_W(CW)) dut (
      .clk(clk), .resetn(resetn),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_len(cfg_len),
      .cfg_pattern(cfg_pattern), .cfg_en(cfg_en), .cfg_err(cfg_err),
      .din_valid(din_valid), .din(din), .overlap(overlap),
      .cnt_clr(cnt_clr), .hit(hit), .hit_any(hit_any),
      .hit_idx(hit_idx), .hit_cnt(hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit tail_eq(int len, logic [7:0] pat);
      for (int k = 0; k < len; k++)
         if (strm[strm.size() - 1 - k] != pat[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      bit ok;
      if (!resetn) begin
         for (int i = 0; i < NP; i++) begin
            m_en[i] = 0; m_len[i] = 0; m_pat[i] = '0; m_start[i] = 0;
         end
         nb = 0; strm.delete();
         e_hit = '0; e_cnt = 0; e_err = 1'b0;
         return;
      end
      ok = cfg_we && cfg_len >= 1 && cfg_len <= ML;
      e_err = cfg_we && !ok;
      e_hit = '0;
      if (din_valid) begin
         strm.push_back(din);
         nb++;
         if (strm.size() > 32) void'(strm.pop_front());
      end
      for (int i = 0; i < NP; i++) begin
         if (ok && cfg_idx == i) continue;
         if (din_valid && m_en[i] && (nb - m_start[i] >= m_len[i]) &&
             tail_eq(m_len[i], m_pat[i])) begin
            e_hit[i] = 1'b1;
            if (!overlap) m_start[i] = nb;
         end
      end
      if (ok) begin
         m_en[cfg_idx] = cfg_en;
         m_len[cfg_idx] = cfg_len;
         m_pat[cfg_idx] = cfg_pattern;
         m_start[cfg_idx] = nb;
      end
      if (cnt_clr) e_cnt = 0;
      else if (e_hit != 0 && e_cnt < 3) e_cnt++;
   endtask

   function automatic int low_idx(logic [3:0] h);
      for (int i = 0; i < NP; i++) if (h[i]) return i;
      return 0;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("hit", 32'(hit), 32'(e_hit));
      chk("hit_any", 32'(hit_any), 32'(e_hit != 0));
      chk("hit_idx", 32'(hit_idx), 32'(low_idx(e_hit)));
      chk("hit_cnt", 32'(hit_cnt), 32'(e_cnt));
      chk("cfg_err", 32'(cfg_err), 32'(e_err));
      cfg_we = 1'b0;
      cnt_clr = 1'b0;
      din_valid = 1'b0;
   endtask

   task automatic set_cfg(int idx, int len, logic [7:0] pat, bit en);
      cfg_we = 1'b1;
      cfg_idx = 2'(idx);
      cfg_len = 4'(len);
      cfg_pattern = pat;
      cfg_en = en;
   endtask

   task automatic beat(bit b);
      din_valid = 1'b1;
      din = b;
      tick();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic beats(logic [7:0] v, int n);
      for (int k = n - 1; k >= 0; k--) beat(v[k]);
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_hit", 32'(hit), 0);
      chk("rst_cnt", 32'(hit_cnt), 0);

      // overlapping 1011 on 1011011
      set_cfg(0, 4, 8'b1011, 1); tick();
      overlap = 1'b1;
      beats(8'b1011011, 7);
      chk("ovl_cnt", 32'(hit_cnt), 2);

      // non-overlapping
      do_reset();
      set_cfg(0, 4, 8'b1011, 1); tick();
      overlap = 1'b0;
      beats(8'b1011011, 7);
      chk("novl_cnt", 32'(hit_cnt), 1);

      // two slots hitting together
      do_reset();
      overlap = 1'b1;
      set_cfg(0, 4, 8'b1011, 1); tick();
      set_cfg(1, 2, 8'b11, 1); tick();
      beat(1);
      chk("two_b1", 32'(hit), 0);
      beats(8'b011, 3);
      chk("two_hit", 32'(hit), 32'b0011);
      chk("two_idx", 32'(hit_idx), 0);
      chk("two_cnt", 32'(hit_cnt), 1);

      // gap of non-beat cycles mid-pattern
      do_reset();
      set_cfg(0, 4, 8'b1011, 1); tick();
      beats(8'b10, 2);
      for (int k = 0; k < 3; k++) begin
         din = k[0];
         tick();
         chk("gap_hit", 32'(hit), 0);
      end
      beats(8'b11, 2);
      chk("gap_end", 32'(hit[0]), 1);

      // rejected writes, then rewrite on beat 3
      set_cfg(2, 0, 8'hff, 1); tick();
      chk("err_len0", 32'(cfg_err), 1);
      set_cfg(2, 9, 8'hff, 1); tick();
      chk("err_len9", 32'(cfg_err), 1);
      tick();
      beats(8'b10, 2);
      set_cfg(0, 4, 8'b1011, 1);
      beat(1);
      beat(1);
      chk("rw_nohit", 32'(hit[0]), 0);

      // saturation, clear-with-hit, mid-pattern reset
      do_reset();
      set_cfg(1, 1, 8'b1, 1); tick();
      beats(8'b11111, 5);
      chk("sat_cnt", 32'(hit_cnt), 3);
      cnt_clr = 1'b1;
      beat(1);
      chk("clr_cnt", 32'(hit_cnt), 0);
      set_cfg(0, 4, 8'b1011, 1); tick();
      beats(8'b101, 3);
      do_reset();
      beats(8'b11111111, 8);
      chk("post_rst", 32'(hit_cnt), 0);

      // random traffic against the model
      for (int i = 0; i < NP; i++) begin
         set_cfg(i, $urandom_range(1, 4), 8'($urandom), 1);
         tick();
      end
      for (int c = 0; c < 1500; c++) begin
         resetn = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 9) == 0)
            set_cfg($urandom_range(0, 3), $urandom_range(0, 10),
                    8'($urandom), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) overlap = ~overlap;
         cnt_clr = ($urandom_range(0, 9) == 0);
         din_valid = ($urandom_range(0, 3) != 0);
         din = 1'($urandom);
         tick();
      end
      resetn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
